// File: rtl/mdac_pkg.sv
// Shared encodings for the multiply/accumulate sequencer: request opcodes and
// controller states.
package mdac_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_MAC = 2'b01,
    OP_CLR = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ITER  = 2'b01,
    S_ACCUM = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/mdac_shift_add.sv
// Shift-add multiplier datapath: one multiplier bit is consumed per step, and
// the product builds up in a 2*WIDTH register that cannot overflow.
module mdac_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // The step that sees the final count is the last of exactly WIDTH iterations.
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign prod_o = prod_q;

endmodule

// File: rtl/mdac_seq.sv
// Multiply/accumulate sequencer: accepts MUL/MAC/CLR requests in IDLE, drives
// the shift-add datapath, then writes or accumulates the product.
module mdac_seq
  import mdac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               loadDp, stepDp, lastIter;
  logic [2*WIDTH-1:0] prod;
  logic [ACC_W:0]     macSum;

  mdac_shift_add #(
    .WIDTH (WIDTH)
  ) u_shift_add (
    .clk    (clk),
    .reset  (reset),
    .load_i (loadDp),
    .step_i (stepDp),
    .a_i    (a),
    .b_i    (b),
    .prod_o (prod),
    .last_o (lastIter)
  );

  // One extra bit so the accumulator carry-out is visible for overflow.
  assign macSum = {1'b0, result_q} + (ACC_W + 1)'(prod);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    loadDp     = 1'b0;
    stepDp     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (op == OP_MUL || op == OP_MAC)) begin
          loadDp  = 1'b1;
          op_d    = op_e'(op);
          state_d = S_ITER;
        end else if (start && op == OP_CLR) begin
          result_d   = '0;
          overflow_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_ITER: begin
        stepDp = 1'b1;
        if (lastIter) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (op_q == OP_MAC) begin
          result_d   = macSum[ACC_W-1:0];
          overflow_d = overflow_q | macSum[ACC_W];
        end else begin
          result_d = ACC_W'(prod);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MUL;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake outputs come straight from registered state.
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: doc/mdac_seq.md
Name: mdac_seq

Overview:
- Sequencing controller for the multiply/accumulate datapath. It accepts an operation request and runs an unsigned shift-add multiply, one multiplier bit per clock, over datapath registers.
- It then writes the product into, or adds it to, an accumulator, and reports completion with a one-cycle pulse.
- It sits between the command source and the flip-flop-based datapath registers. It owns all state sequencing, handshake and overflow tracking.

Parameters:
- WIDTH, 8, operand width in bits (minimum 2).
- ACC_W, 20, accumulator/result width in bits (must be ≥ 2*WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  operation: 00 MUL, 01 MAC, 10 CLR, 11 NOP.
- a  input  WIDTH  multiplicand, captured when start is accepted.
- b  input  WIDTH  multiplier, captured when start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  ACC_W  accumulator contents.
- overflow  output  1  sticky accumulator carry-out flag.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; busy=0, done=0, result=0, overflow=0.
  - mcand, mplier, prod and cnt all 0.
  - Takes effect immediately, without waiting for a clock edge.
- States: IDLE, ITER, ACCUM, DONE.
- IDLE, start=1, op=MUL or MAC:
  - mcand ← zero-extended a; mplier ← b; prod ← 0; cnt ← 0.
  - Latch op; go to ITER.
- IDLE, start=1, op=CLR: result ← 0, overflow ← 0; go to DONE.
- IDLE, start=1, op=NOP: ignored. Stay in IDLE, no done.
- ITER, each edge:
  - If mplier[0]=1: prod ← prod + mcand (2*WIDTH bits, no overflow possible).
  - mcand ← mcand<<1; mplier ← mplier>>1; cnt ← cnt+1.
  - When cnt=WIDTH-1 on this edge, go to ACCUM. This gives exactly WIDTH ITER cycles, with no early exit on a zero multiplier.
- ACCUM, one edge:
  - MUL: result ← zero-extended prod. overflow is unchanged.
  - MAC: result ← (result + prod) mod 2^ACC_W. overflow ← overflow | carry-out.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE on the next edge.
- Latency: start accepted at edge k gives done high in the cycle following edge k+WIDTH+1 (WIDTH+2 cycles, 10 for WIDTH=8). For CLR, done is high in the cycle after the accepting edge.
- start while busy (including during DONE) is ignored and not queued. The requester must hold or re-assert start in an IDLE cycle.
- Back-to-back issue: the earliest next accept is the first IDLE cycle after DONE, giving a throughput of one op per WIDTH+3 cycles.
- a, b and op may change freely after acceptance, since they are captured at accept.
- result changes only at the ACCUM edge, the CLR accept edge, or reset. It is stable while busy otherwise.
- overflow clears only on CLR or reset.
- busy and done are decoded from registered state only (glitch-free, no combinational path from inputs).

Decomposition:
- mdac_pkg holds:
  - op encodings OP_MUL=2'b00, OP_MAC=2'b01, OP_CLR=2'b10, OP_NOP=2'b11.
  - state encodings S_IDLE, S_ITER, S_ACCUM, S_DONE (2-bit binary).
- One sub-module is natural: mdac_shift_add. It holds the mcand/mplier/prod/cnt registers and the adder, with load/step controls driven by the mdac_seq FSM.
- The accumulator, overflow flag and FSM stay in mdac_seq.

Test Plan:
- MUL a=13, b=11, WIDTH=8: expect busy high 10 cycles, done pulse at cycle 10, result=143, overflow=0.
- CLR, then 16× MAC a=255, b=255:
  - After 16 MACs: result=1040400 (0xFE010), overflow=0.
  - 17th MAC: result=56849 (1105425 mod 2^20), overflow=1.
  - A following MUL 2×3 gives result=6 with overflow still 1.
  - CLR clears both.
- Ignored requests:
  - start with op=NOP gives no busy and no done, result unchanged.
  - start pulses during ITER, ACCUM and DONE of a MUL 7×9 are ignored: exactly one done, result=63.
  - start held high through DONE is accepted on the first IDLE cycle.
- Zero operands: MUL a=0, b=200 and MUL a=200, b=0 both take the full 10 cycles with result=0. MUL a=255, b=255 gives 65025.
- Reset mid-operation: assert reset asynchronously (between edges) during ITER cycle 4 of MUL 100×100.
  - busy, done, result and overflow go to 0 immediately.
  - After release, a new MUL 5×5 completes normally with result=25 in 10 cycles.
